// File: rtl/fifo_pkg.sv
// Shared definitions for the async_fifo family: default data width, default
// buffer sizing and the helper that turns a buffer depth into a pointer width.
package fifo_pkg;

    localparam int DEFAULT_WIDTH     = 16;
    localparam int DEFAULT_BUF_DEPTH = 4;
    localparam int DEFAULT_FRAME_LEN = 8;

    // Word counter type for framing, wide enough for frames up to 65535 words.
    typedef logic [15:0] wcnt_t;

    // Pointer width for a power-of-two depth; a depth of 1 or 2 still needs one bit.
    function automatic int ptrWidth(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/stream_buf.sv
// Small circular buffer between the FIFO read port and the output stream.
// Writes come from captured FIFO words, reads happen on stream handshakes.
// The head entry is always presented on o_data straight from storage.
module stream_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_BUF_DEPTH,
    localparam int PTR_W = ptrWidth(DEPTH),
    localparam int OCC_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_data,
    output logic [OCC_W-1:0] o_occ
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [OCC_W-1:0] r_occ;

    // Storage and write pointer; storage is cleared so the idle output reads zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr <= '0;
        end else if (i_wr) begin
            r_mem[r_wptr] <= i_wdata;
            r_wptr        <= r_wptr + PTR_W'(1);
        end
    end

    // Read pointer advances on every accepted output word, wrapping with the depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr <= '0;
        end else if (i_rd) begin
            r_rptr <= r_rptr + PTR_W'(1);
        end
    end

    // Occupancy tracks entries held; a write and read in the same cycle cancel out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else begin
            case ({i_wr, i_rd})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    assign o_data = r_mem[r_rptr];
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drain controller for the read side of async_fifo. Reads are issued only when
// the buffer can absorb every word already requested, so backpressure on the
// output stream never loses a FIFO word. Output words are framed with m_last.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int BUF_DEPTH = DEFAULT_BUF_DEPTH,
    parameter int FRAME_LEN = DEFAULT_FRAME_LEN
) (
    input  logic             rd_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             empty,
    input  logic             valid,
    input  logic [WIDTH-1:0] dout,
    output logic             rd_en,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             m_ready,
    output logic             err
);

    localparam int               OCC_W     = ptrWidth(BUF_DEPTH) + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(BUF_DEPTH);
    localparam wcnt_t            LAST_IDX  = wcnt_t'(FRAME_LEN - 1);

    logic             r_inflight;
    logic             r_err;
    wcnt_t            r_wcnt;
    logic [OCC_W-1:0] w_occ;
    logic [OCC_W-1:0] w_credit;
    logic             w_capture;
    logic             w_handshake;

    // Words held plus the word still coming back from the FIFO must leave a free slot.
    assign w_credit    = w_occ + {{(OCC_W-1){1'b0}}, r_inflight};
    assign rd_en       = !rst && en && !empty && (w_credit < DEPTH_OCC);

    // Only a return that matches an outstanding request is stored; strays are dropped.
    assign w_capture   = valid && r_inflight;
    assign m_valid     = (w_occ != '0);
    assign w_handshake = m_valid && m_ready;
    assign m_last      = m_valid && (r_wcnt == LAST_IDX);
    assign err         = r_err;

    stream_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (rd_clk),
        .rst     (rst),
        .i_wr    (w_capture),
        .i_wdata (dout),
        .i_rd    (w_handshake),
        .o_data  (m_data),
        .o_occ   (w_occ)
    );

    // Remember whether a read was issued, so next cycle's valid is expected.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= rd_en;
        end
    end

    // Framing counter steps on each delivered word and wraps at the frame length.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_wcnt <= '0;
        end else if (w_handshake) begin
            if (r_wcnt == LAST_IDX) begin
                r_wcnt <= '0;
            end else begin
                r_wcnt <= r_wcnt + wcnt_t'(1);
            end
        end
    end

    // Sticky flag for a FIFO return that nobody asked for.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (valid && !r_inflight) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds the drain controller,
// every word pushed is expected back in order, and a monitor checks the stream.
module tb_fifo_rd_stream;

   localparam int WIDTH     = 16;
   localparam int BUF_DEPTH = 4;
   localparam int FRAME_LEN = 8;

   logic             rd_clk = 1'b0;
   logic             rst = 1'b1;
   logic             en = 1'b0;
   logic             empty = 1'b1;
   logic             valid = 1'b0;
   logic [WIDTH-1:0] dout = '0;
   logic             rd_en;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_last;
   logic             m_ready = 1'b0;
   logic             err;

   int               tests = 0;
   int               fails = 0;
   logic [WIDTH-1:0] fifoQ[$];
   logic [WIDTH-1:0] expQ[$];
   int               rdCount = 0;
   int               hsCount = 0;
   int               cyc = 0;
   int               firstRdCycle = -1;
   int               firstHsCycle = -1;
   int               lastHsCycle = -1;
   bit               injectValid = 1'b0;
   bit               rdSample = 1'b0;
   bit               prevStall = 1'b0;
   logic [WIDTH-1:0] prevData = '0;

   fifo_rd_stream #(
      .WIDTH     (WIDTH),
      .BUF_DEPTH (BUF_DEPTH),
      .FRAME_LEN (FRAME_LEN)
   ) dut (
      .rd_clk  (rd_clk),
      .rst     (rst),
      .en      (en),
      .empty   (empty),
      .valid   (valid),
      .dout    (dout),
      .rd_en   (rd_en),
      .m_valid (m_valid),
      .m_data  (m_data),
      .m_last  (m_last),
      .m_ready (m_ready),
      .err     (err)
   );

   // Free-running read clock
   always #5 rd_clk = ~rd_clk;

   // Compare one observed value with the bench's expectation and tally the result
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Push a run of words into the FIFO model; each one is owed back on the stream
   task automatic applyStimulus(input int n, input int base);
      for (int i = 0; i < n; i++) begin
         fifoQ.push_back(WIDTH'(base + i));
         expQ.push_back(WIDTH'(base + i));
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge rd_clk);
      #3;
   endtask

   // Let the stream empty out the expected queue within a cycle budget
   task automatic waitDrain(input string name, input int budget);
      int k;
      k = 0;
      while (expQ.size() != 0 && k < budget) begin
         @(posedge rd_clk);
         #3;
         k++;
      end
      checkOutput(name, 32'(expQ.size()), 32'd0);
   endtask

   // Assert reset, confirm outputs fall immediately, then release with fresh bookkeeping
   task automatic doReset();
      rst = 1'b1;
      en = 1'b0;
      m_ready = 1'b0;
      injectValid = 1'b0;
      #1;
      checkOutput("rst_rd_en", 32'(rd_en), 32'd0);
      checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
      checkOutput("rst_m_last", 32'(m_last), 32'd0);
      checkOutput("rst_m_data", 32'(m_data), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      repeat (2) @(posedge rd_clk);
      #3;
      expQ.delete();
      rdCount = 0;
      hsCount = 0;
      firstRdCycle = -1;
      firstHsCycle = -1;
      lastHsCycle = -1;
      rst = 1'b0;
   endtask

   // FIFO model: pops on a sampled rd_en and returns the word one cycle later
   initial begin
      forever begin
         @(negedge rd_clk);
         rdSample = rd_en;
         @(posedge rd_clk);
         cyc++;
         #1;
         if (rst) begin
            valid = 1'b0;
         end else if (rdSample) begin
            if (fifoQ.size() == 0) begin
               valid = 1'b0;
               checkOutput("read_from_empty_fifo", 32'd1, 32'd0);
            end else begin
               valid = 1'b1;
               dout = fifoQ.pop_front();
            end
         end else if (injectValid) begin
            valid = 1'b1;
            dout = 16'hDEAD;
            injectValid = 1'b0;
         end else begin
            valid = 1'b0;
         end
         #3;
         if (rst) fifoQ.delete();
         empty = (fifoQ.size() == 0);
      end
   end

   // Monitor: checks the stream head against the expected queue and pops on handshakes
   initial begin
      forever begin
         @(negedge rd_clk);
         if (rst) begin
            prevStall = 1'b0;
            continue;
         end
         checkOutput("rd_en_while_empty", 32'(rd_en && empty), 32'd0);
         checkOutput("m_last_without_valid", 32'(!m_valid && m_last), 32'd0);
         if (prevStall) checkOutput("held_data", 32'(m_data), 32'(prevData));
         if (rd_en) begin
            rdCount++;
            if (firstRdCycle < 0) firstRdCycle = cyc;
         end
         checkOutput("buffer_bound", 32'((rdCount - hsCount) <= BUF_DEPTH), 32'd1);
         if (m_valid) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
               checkOutput("stream_data", 32'(m_data), 32'(expQ[0]));
               checkOutput("stream_last", 32'(m_last), 32'((hsCount % FRAME_LEN) == FRAME_LEN - 1));
               if (m_ready) begin
                  void'(expQ.pop_front());
                  hsCount++;
                  if (firstHsCycle < 0) firstHsCycle = cyc;
                  lastHsCycle = cyc;
               end
            end
         end
         prevStall = m_valid && !m_ready;
         prevData = m_data;
      end
   end

   // Guard against a hung run
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenarios followed by a randomized soak
   initial begin
      int k;
      @(posedge rd_clk);
      #3;
      doReset();

      // Full-rate streaming of 32 words
      en = 1'b1;
      m_ready = 1'b1;
      applyStimulus(32, 0);
      waitDrain("t1_drain", 100);
      checkOutput("t1_latency", 32'(firstHsCycle - firstRdCycle), 32'd2);
      checkOutput("t1_throughput", 32'(lastHsCycle - firstHsCycle), 32'd31);
      checkOutput("t1_reads", 32'(rdCount), 32'd32);

      // Backpressure caps requests at the buffer depth, then releases without gaps
      doReset();
      en = 1'b1;
      applyStimulus(12, 0);
      waitCycles(10);
      checkOutput("t2_reads_capped", 32'(rdCount), 32'd4);
      checkOutput("t2_m_valid", 32'(m_valid), 32'd1);
      checkOutput("t2_m_data", 32'(m_data), 32'd0);
      m_ready = 1'b1;
      waitDrain("t2_drain", 60);
      checkOutput("t2_no_gap", 32'(lastHsCycle - firstHsCycle), 32'd11);

      // Alternating ready over 20 words
      doReset();
      en = 1'b1;
      applyStimulus(20, 0);
      k = 0;
      while (expQ.size() != 0 && k < 100) begin
         m_ready = ~m_ready;
         @(posedge rd_clk);
         #3;
         k++;
      end
      checkOutput("t3_words", 32'(hsCount), 32'd20);

      // Enable dropped after the fifth read, framing continues afterwards
      doReset();
      en = 1'b1;
      m_ready = 1'b1;
      applyStimulus(16, 0);
      k = 0;
      while (rdCount < 5 && k < 50) begin
         @(posedge rd_clk);
         #3;
         k++;
      end
      en = 1'b0;
      waitCycles(6);
      checkOutput("t4_reads_stopped", 32'(rdCount), 32'd5);
      checkOutput("t4_words_delivered", 32'(hsCount), 32'd5);
      en = 1'b1;
      waitDrain("t4_drain", 60);
      checkOutput("t4_words_total", 32'(hsCount), 32'd16);

      // Unrequested valid sets a sticky error and is dropped
      doReset();
      m_ready = 1'b1;
      injectValid = 1'b1;
      waitCycles(2);
      checkOutput("t5_err_set", 32'(err), 32'd1);
      checkOutput("t5_no_m_valid", 32'(m_valid), 32'd0);
      waitCycles(5);
      checkOutput("t5_err_sticky", 32'(err), 32'd1);
      checkOutput("t5_no_words", 32'(hsCount), 32'd0);

      // Reset with three words buffered and a read pending
      doReset();
      en = 1'b1;
      applyStimulus(3, 40);
      waitCycles(6);
      checkOutput("t6_reads", 32'(rdCount), 32'd3);
      applyStimulus(5, 50);
      #3;
      checkOutput("t6_rd_en_before_rst", 32'(rd_en), 32'd1);
      checkOutput("t6_m_valid_before_rst", 32'(m_valid), 32'd1);
      doReset();
      en = 1'b1;
      m_ready = 1'b1;
      applyStimulus(10, 100);
      waitDrain("t6_restart_drain", 60);
      checkOutput("t6_restart_words", 32'(hsCount), 32'd10);

      // Randomized pushes, enable and ready
      doReset();
      en = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 2) == 0) applyStimulus(int'($urandom_range(1, 3)), int'($urandom_range(0, 65000)));
         m_ready = ($urandom_range(0, 3) != 0);
         en = ($urandom_range(0, 9) != 0);
         @(posedge rd_clk);
         #3;
      end
      en = 1'b1;
      m_ready = 1'b1;
      waitDrain("t7_random_drain", 400);
      checkOutput("t7_fifo_empty", 32'(fifoQ.size()), 32'd0);
      checkOutput("t7_err_clear", 32'(err), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
